mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Multi-cycle load/store initiator sitting between the CPU datapath and the word-wide data memory.
- Accepts one byte/halfword/word load or store request from the core and drives the memory's ce/we/addr/wtData interface.
- Sign- or zero-extends load data; performs read-modify-write for sub-word stores.
- Reports misaligned accesses without touching memory.

Parameters:
- ADDR_W, 32, width of the core and memory address buses. Data width is fixed at 32.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- req  in  1  request strobe; sampled only in IDLE
- op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
- addr  in  ADDR_W  byte address
- wdata  in  32  store data; SH uses [15:0], SB uses [7:0]
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result
- addr_err  out  1  misalignment flag, valid with done
- mem_ce  out  1  memory chip enable (1 = RamEnable)
- mem_we  out  1  memory write enable (1 = RamWrite)
- mem_addr  out  ADDR_W  word address to memory, bits [1:0] always 00
- mem_wdata  out  32  write data to memory
- mem_rdata  in  32  combinational read data from memory; 0 when ce is low

Behaviour:
- Byte lanes are little-endian: byte k = bits [8k+7:8k], selected by addr[1:0]=k; halfword h = bits [16h+15:16h], selected by addr[1].
- States: IDLE, RD, WR, RESP.
- IDLE, req=1: capture op, addr, wdata into internal registers, then branch:
  - misaligned access -> RESP with addr_err=1. Misaligned means LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0.
  - load -> RD.
  - SW -> WR.
  - SH/SB -> RD.
- IDLE, req=0: remain in IDLE.
- RD: mem_ce=1, mem_we=0. At the clock edge, latch mem_rdata into an internal word register.
  - Load: also load the extracted and extended value into rdata, then go to RESP.
  - SH/SB: go to WR.
- WR: mem_ce=1, mem_we=1.
  - SW: mem_wdata = captured wdata.
  - SH/SB: mem_wdata = latched word with the selected lane replaced by wdata[15:0] or wdata[7:0]; other lanes unchanged.
  - The memory commits the write at the clock edge ending WR; the next state is RESP.
- RESP: done=1 for exactly this cycle; addr_err=1 here only for the misalignment path. Next state is IDLE.
- Latency from the req cycle (cycle 0) to the done cycle:
  - loads: done in cycle 2
  - SW: done in cycle 2
  - SH/SB: done in cycle 3
  - misaligned: done in cycle 1
- Throughput: one request per (latency+1) cycles. The next req is accepted in the cycle after done.
- Extension:
  - LB sign-extends bit 7 of the lane.
  - LH sign-extends bit 15 of the lane.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- Output timing:
  - mem_ce, mem_we, mem_addr and mem_wdata are decoded only from the state and captured registers; there is no combinational path from req, addr or wdata.
  - mem_ce=0 and mem_we=0 in IDLE and RESP.
  - mem_addr = {captured addr[ADDR_W-1:2], 2'b00} in RD/WR, and 0 otherwise.
- Hold behaviour:
  - rdata holds the last load result and is unchanged by stores and errors.
  - addr_err holds its value until the next done.
- A req raised while busy is ignored: not queued, no effect.
- Address wrap: none. mem_addr is the truncated word address, so the memory's own index masking applies.
- Reset:
  - state=IDLE, busy=0, done=0, rdata=0, addr_err=0, mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0, internal registers 0.
  - mem_ce and mem_we are gated by !rst, so a WR cycle with rst=1 performs no write.
  - Reset mid-RMW after RD but before WR leaves memory unmodified; no done pulse is produced.
- Unknown op is impossible because all 8 codes are defined.

Test Plan:
- LB and LBU sign/zero extension: preload word 0x80FF7F01 at byte 0x10; LB addr=0x13 -> done in cycle 2, rdata=0xFFFFFF80. LBU addr=0x13 -> rdata=0x00000080. LB addr=0x11 -> rdata=0x0000007F.
- LH and LHU: same word. LH addr=0x12 -> rdata=0xFFFF80FF. LHU addr=0x12 -> rdata=0x000080FF. LH addr=0x10 -> rdata=0x00007F01.
- SB read-modify-write: word 0x11223344 at 0x20; SB addr=0x21, wdata=0xAB -> RD then WR with mem_wdata=0x1122AB44, done in cycle 3. A subsequent LW 0x20 returns 0x1122AB44. SW 0x24, wdata=0xDEADBEEF -> single WR cycle, done in cycle 2.
- Misalignment: LW addr=0x02, SH addr=0x05, LHU addr=0x07 -> each gives done in cycle 1 with addr_err=1. mem_ce stays 0 throughout, and rdata keeps its previous value.
- Busy handling and back-to-back requests: req held high continuously with LW ops -> done every 3 cycles. Toggling addr while busy has no effect on mem_addr.
- Reset during SB at the WR cycle: rst=1 in the WR cycle -> mem_we=0 that cycle, no done, the memory word is unchanged. All outputs are 0 next cycle and the next req is accepted normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - multi-cycle byte/halfword/word load/store initiator with sub-word RMW
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              addr_err,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  logic [1:0]        state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;

  // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
  function automatic logic is_misaligned(input logic [2:0] o, input logic [1:0] a);
    logic m;
    m = 1'b0;
    case (o)
      OP_LW, OP_SW:          m = (a != 2'b00);
      OP_LH, OP_LHU, OP_SH:  m = a[0];
      default:               m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic is_load(input logic [2:0] o);
    return (o <= OP_LBU);
  endfunction

  // Select the addressed lane of a memory word and sign/zero extend it.
  function automatic logic [31:0] extend_lane(input logic [2:0] o, input logic [31:0] w,
                                              input logic [1:0] a);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = a[1] ? w[31:16] : w[15:0];
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    case (o)
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0000, h};
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h000000, b};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed halfword/byte lane of the latched word with store data.
  function automatic logic [31:0] merge_lane(input logic [2:0] o, input logic [31:0] w,
                                             input logic [31:0] d, input logic [1:0] a);
    logic [31:0] m;
    m = w;
    if (o == OP_SH) begin
      if (a[1]) m[31:16] = d[15:0];
      else      m[15:0]  = d[15:0];
    end else begin
      case (a)
        2'd0:    m[7:0]   = d[7:0];
        2'd1:    m[15:8]  = d[7:0];
        2'd2:    m[23:16] = d[7:0];
        default: m[31:24] = d[7:0];
      endcase
    end
    return m;
  endfunction

  // Sequencer: capture the request, walk RD/WR as needed, then report in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      word_q   <= 32'd0;
      rdata    <= 32'd0;
      addr_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            op_q    <= op;
            addr_q  <= addr;
            wdata_q <= wdata;
            if (is_misaligned(op, addr[1:0])) begin
              addr_err <= 1'b1;
              state    <= S_RESP;
            end else if (op == OP_SW) begin
              state <= S_WR;
            end else begin
              state <= S_RD;
            end
          end
        end
        S_RD: begin
          word_q <= mem_rdata;
          if (is_load(op_q)) begin
            rdata    <= extend_lane(op_q, mem_rdata, addr_q[1:0]);
            addr_err <= 1'b0;
            state    <= S_RESP;
          end else begin
            state <= S_WR;
          end
        end
        S_WR: begin
          addr_err <= 1'b0;
          state    <= S_RESP;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory-side and status outputs decode only state and captured registers.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_RESP);
    mem_ce    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    if (!rst && (state == S_RD || state == S_WR)) begin
      mem_ce   = 1'b1;
      mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
      if (state == S_WR) begin
        mem_we    = 1'b1;
        mem_wdata = (op_q == OP_SW) ? wdata_q : merge_lane(op_q, word_q, wdata_q, addr_q[1:0]);
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - table-driven and randomized checks of mem_access_ctrl against a memory model
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        addr_err;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_access_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .addr_err(addr_err),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 64-word memory with a bench-side preload port.
  logic [31:0] mem [64];
  logic        ld_en;
  logic [5:0]  ld_idx;
  logic [31:0] ld_val;

  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_val;
    else if (mem_ce && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  assign mem_rdata = mem_ce ? mem[mem_addr[7:2]] : 32'd0;

  // Reference state: expected memory contents and last load result.
  logic [31:0] ref_mem [64];
  logic [31:0] ref_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_idx = idx[5:0]; ld_val = v;
    @(negedge clk);
    ld_en = 1'b0;
    ref_mem[idx] = v;
  endtask

  // Behavioural model: byte k of a word is (w >> 8k) & 0xFF, stores mask-and-or the lane.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] exp_rd, output logic exp_err, output int exp_lat,
                       output int exp_wr, output logic [31:0] exp_wd);
    int          idx;
    int          k;
    int          hs;
    logic [31:0] w;
    logic [31:0] bt;
    logic [31:0] hw;
    logic [31:0] mask;
    idx = int'(a[7:2]);
    k   = int'(a[1:0]);
    hs  = 16 * int'(a[1]);
    w   = ref_mem[idx];
    exp_wr = 0;
    exp_wd = 32'd0;
    exp_err = 1'b0;
    if (((o == 3'd0 || o == 3'd5) && k != 0) || ((o == 3'd1 || o == 3'd2 || o == 3'd6) && a[0])) begin
      exp_err = 1'b1;
      exp_lat = 1;
    end else if (o <= 3'd4) begin
      bt = (w >> (8 * k)) & 32'hFF;
      hw = (w >> hs) & 32'hFFFF;
      case (o)
        3'd0: ref_rdata = w;
        3'd1: ref_rdata = (hw >= 32'h8000) ? (hw | 32'hFFFF0000) : hw;
        3'd2: ref_rdata = hw;
        3'd3: ref_rdata = (bt >= 32'h80) ? (bt | 32'hFFFFFF00) : bt;
        default: ref_rdata = bt;
      endcase
      exp_lat = 2;
    end else begin
      if (o == 3'd5) begin
        ref_mem[idx] = wd;
        exp_lat = 2;
      end else if (o == 3'd6) begin
        mask = 32'hFFFF << hs;
        ref_mem[idx] = (w & ~mask) | ((wd & 32'hFFFF) << hs);
        exp_lat = 3;
      end else begin
        mask = 32'hFF << (8 * k);
        ref_mem[idx] = (w & ~mask) | ((wd & 32'hFF) << (8 * k));
        exp_lat = 3;
      end
      exp_wr = 1;
      exp_wd = ref_mem[idx];
    end
    exp_rd = ref_rdata;
  endtask

  // Issue one request and watch until done (bounded); latency 0 means no done seen.
  task automatic do_req(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic err,
                        output int ce_cnt, output int wr_cnt, output logic [31:0] wr_data);
    @(negedge clk);
    req = 1'b1; op = o; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0;
    lat = 0; ce_cnt = 0; wr_cnt = 0; wr_data = 32'd0; rd = 32'd0; err = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (mem_ce) ce_cnt++;
      if (mem_ce && mem_we) begin
        wr_cnt++;
        wr_data = mem_wdata;
      end
      if (done) begin
        lat = c;
        rd  = rdata;
        err = addr_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int          lat;
    int          ce_cnt;
    int          wr_cnt;
    int          m_lat;
    int          m_wr;
    int          bad_words;
    int          dcyc [4];
    int          nd;
    logic [31:0] rd;
    logic [31:0] wr_data;
    logic [31:0] m_rd;
    logic [31:0] m_wd;
    logic [31:0] ra;
    logic [2:0]  ro;
    logic        err;
    logic        m_err;

    vecs[0]  = '{3'd3, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0, 32'h0};
    vecs[1]  = '{3'd4, 32'h13, 32'h0,        32'h00000080, 1'b0, 2, 0, 32'h0};
    vecs[2]  = '{3'd3, 32'h11, 32'h0,        32'h0000007F, 1'b0, 2, 0, 32'h0};
    vecs[3]  = '{3'd1, 32'h12, 32'h0,        32'hFFFF80FF, 1'b0, 2, 0, 32'h0};
    vecs[4]  = '{3'd2, 32'h12, 32'h0,        32'h000080FF, 1'b0, 2, 0, 32'h0};
    vecs[5]  = '{3'd1, 32'h10, 32'h0,        32'h00007F01, 1'b0, 2, 0, 32'h0};
    vecs[6]  = '{3'd7, 32'h21, 32'h000000AB, 32'h00007F01, 1'b0, 3, 1, 32'h1122AB44};
    vecs[7]  = '{3'd0, 32'h20, 32'h0,        32'h1122AB44, 1'b0, 2, 0, 32'h0};
    vecs[8]  = '{3'd5, 32'h24, 32'hDEADBEEF, 32'h1122AB44, 1'b0, 2, 1, 32'hDEADBEEF};
    vecs[9]  = '{3'd0, 32'h24, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'h0};
    vecs[10] = '{3'd0, 32'h02, 32'h0,        32'hDEADBEEF, 1'b1, 1, 0, 32'h0};
    vecs[11] = '{3'd6, 32'h05, 32'h5555,     32'hDEADBEEF, 1'b1, 1, 0, 32'h0};
    vecs[12] = '{3'd2, 32'h07, 32'h0,        32'hDEADBEEF, 1'b1, 1, 0, 32'h0};

    rst = 1'b1; req = 1'b0; op = 3'd0; addr = 32'd0; wdata = 32'd0;
    ld_en = 1'b0; ld_idx = 6'd0; ld_val = 32'd0;
    ref_rdata = 32'd0;

    for (int i = 0; i < 64; i++) preload(i, $urandom);
    preload(4, 32'h80FF7F01);
    preload(8, 32'h11223344);

    @(negedge clk);
    chk("reset_status", {29'd0, busy, done, addr_err}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_mem_ctl", {30'd0, mem_ce, mem_we}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    // Directed table from the documented scenarios.
    for (int i = 0; i < 13; i++) begin
      model(vecs[i].o, vecs[i].a, vecs[i].wd, m_rd, m_err, m_lat, m_wr, m_wd);
      do_req(vecs[i].o, vecs[i].a, vecs[i].wd, lat, rd, err, ce_cnt, wr_cnt, wr_data);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_addr_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_writes", i), wr_cnt, vecs[i].exp_wr);
      if (vecs[i].exp_err) chk($sformatf("vec%0d_ce_cycles", i), ce_cnt, 0);
      if (vecs[i].exp_wr != 0) chk($sformatf("vec%0d_wr_data", i), wr_data, vecs[i].exp_wd);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 80; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = {24'd0, 8'($urandom_range(0, 255))};
      if ($urandom_range(0, 3) != 0) begin
        if (ro == 3'd0 || ro == 3'd5) ra[1:0] = 2'b00;
        else if (ro == 3'd1 || ro == 3'd2 || ro == 3'd6) ra[0] = 1'b0;
      end
      wdata = $urandom;
      model(ro, ra, wdata, m_rd, m_err, m_lat, m_wr, m_wd);
      do_req(ro, ra, wdata, lat, rd, err, ce_cnt, wr_cnt, wr_data);
      chk($sformatf("rnd%0d_latency", i), lat, m_lat);
      chk($sformatf("rnd%0d_rdata", i), rd, m_rd);
      chk($sformatf("rnd%0d_addr_err", i), {31'd0, err}, {31'd0, m_err});
      if (m_wr != 0) chk($sformatf("rnd%0d_wr_data", i), wr_data, m_wd);
    end

    // Back-to-back LW with req held high; addr scrambled while busy.
    model(3'd0, 32'h20, 32'd0, m_rd, m_err, m_lat, m_wr, m_wd);
    @(negedge clk);
    req = 1'b1; op = 3'd0; addr = 32'h20;
    nd = 0;
    for (int c = 1; c <= 20 && nd < 4; c++) begin
      @(negedge clk);
      if (mem_ce) chk($sformatf("b2b_mem_addr_c%0d", c), mem_addr, 32'h20);
      if (done) begin
        dcyc[nd] = c;
        nd++;
        chk($sformatf("b2b_rdata_%0d", nd), rdata, m_rd);
        if (nd == 4) req = 1'b0;
      end
      if (busy) addr = $urandom;
      else addr = 32'h20;
    end
    chk("b2b_done_count", nd, 4);
    chk("b2b_first_done", dcyc[0], 2);
    for (int i = 1; i < 4; i++) chk($sformatf("b2b_interval_%0d", i), dcyc[i] - dcyc[i-1], 3);
    req = 1'b0;

    // Reset asserted during the WR cycle of an SB read-modify-write.
    @(negedge clk);
    req = 1'b1; op = 3'd7; addr = 32'h21; wdata = 32'hCD;
    @(negedge clk);
    req = 1'b0;
    chk("rmw_rd_ctl", {30'd0, mem_ce, mem_we}, 32'd2);
    @(negedge clk);
    chk("rmw_wr_ctl", {30'd0, mem_ce, mem_we}, 32'd3);
    rst = 1'b1;
    #1;
    chk("rmw_wr_gated", {30'd0, mem_ce, mem_we}, 32'd0);
    chk("rmw_wr_no_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("post_rst_status", {29'd0, busy, done, addr_err}, 32'd0);
    chk("post_rst_rdata", rdata, 32'd0);
    chk("post_rst_mem_ctl", {30'd0, mem_ce, mem_we}, 32'd0);
    chk("post_rst_mem_addr", mem_addr, 32'd0);
    chk("post_rst_mem_wdata", mem_wdata, 32'd0);
    chk("rmw_word_unchanged", mem[8], ref_mem[8]);
    rst = 1'b0;
    ref_rdata = 32'd0;
    model(3'd0, 32'h20, 32'd0, m_rd, m_err, m_lat, m_wr, m_wd);
    do_req(3'd0, 32'h20, 32'd0, lat, rd, err, ce_cnt, wr_cnt, wr_data);
    chk("post_rst_lw_latency", lat, m_lat);
    chk("post_rst_lw_rdata", rd, m_rd);

    // Whole-memory agreement with the model.
    bad_words = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad_words++;
    chk("final_memory_words_differing", bad_words, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
